// File: rtl/conv1d_mac_if.sv
// Bus bundle between the convolution wrapper and conv1d_mac_engine.
// It carries the job control (start, sizes, shift, saturation), the X/Y
// read ports, the Z write port and the status flags (busy, done, err).
//   master : wrapper side, which drives job control and the X/Y read data
//   slave  : engine side, which drives the addresses, Z write and status
// The parameters must match the ones given to the engine.
interface conv1d_mac_if #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 32,
   parameter int MAX_X  = 64,
   parameter int MAX_Y  = 64
);
   localparam int XW = $clog2(MAX_X);
   localparam int YW = $clog2(MAX_Y);
   localparam int ZW = $clog2(MAX_X + MAX_Y - 1);

   logic              start;
   logic [XW:0]       size_x;
   logic [YW:0]       size_y;
   logic [4:0]        shift;
   logic              sat_en;
   logic [XW-1:0]     mem_x_addr;
   logic [DATA_W-1:0] mem_x_data;
   logic [YW-1:0]     mem_y_addr;
   logic [DATA_W-1:0] mem_y_data;
   logic [ZW-1:0]     mem_z_addr;
   logic [OUT_W-1:0]  mem_z_data;
   logic              mem_z_we;
   logic              busy;
   logic              done;
   logic              err;

   modport master (
      output start, size_x, size_y, shift, sat_en, mem_x_data, mem_y_data,
      input  mem_x_addr, mem_y_addr, mem_z_addr, mem_z_data, mem_z_we,
             busy, done, err
   );

   modport slave (
      input  start, size_x, size_y, shift, sat_en, mem_x_data, mem_y_data,
      output mem_x_addr, mem_y_addr, mem_z_addr, mem_z_data, mem_z_we,
             busy, done, err
   );
endinterface

// File: rtl/conv1d_mac_engine.sv
// 1-D linear convolution core: Z[n] = sum_k X[k]*Y[n-k], n = 0..Nx+Ny-2.
// One multiply-accumulate per cycle, reading X and Y from synchronous
// memories owned by the wrapper (read data valid one cycle after address).
// Ports:
//   clk    clock
//   rst_a  synchronous active-high reset
//   en_s   clock enable; when low the engine is frozen and mem_z_we is low
//   bus    conv1d_mac_if slave: start/size_x/size_y/shift/sat_en in,
//          X/Y read ports, Z write port, busy/done/err out
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; job parameters latched on accept
// S_MAC   | one X/Y address pair per cycle for output n (k = kmin..kmax);
//         | first MAC cycle also rejects illegal sizes
// S_DRAIN | adds the product for the last address pair issued
// S_WRITE | mem_z_we pulse for Z[n]; advance to next n or finish
// S_DONE  | done pulse, busy low; back to S_IDLE
module conv1d_mac_engine #(
   parameter int DATA_W = 16,
   parameter int OUT_W  = 32,
   parameter int MAX_X  = 64,
   parameter int MAX_Y  = 64,
   parameter bit SIGNED = 1'b1,
   parameter int ACC_W  = 2*DATA_W + 7
) (
   input logic         clk,
   input logic         rst_a,
   input logic         en_s,
   conv1d_mac_if.slave bus
);
   localparam int XW = $clog2(MAX_X);
   localparam int YW = $clog2(MAX_Y);
   localparam int ZW = $clog2(MAX_X + MAX_Y - 1);
   // one spare bit so size compares and n+1 never wrap
   localparam int CW = ZW + 1;

   localparam logic [CW-1:0]    ONE_C   = CW'(1);
   localparam logic [CW-1:0]    TWO_C   = CW'(2);
   localparam logic [XW:0]      MAX_X_L = (XW+1)'(MAX_X);
   localparam logic [YW:0]      MAX_Y_L = (YW+1)'(MAX_Y);
   localparam logic [OUT_W-1:0] SMAX    = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] SMIN    = {1'b1, {(OUT_W-1){1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_DRAIN, S_WRITE, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [CW-1:0]    nx_q, ny_q, n_q, k_q;
   logic [4:0]       shift_q;
   logic             sat_q, bad_q, first_q, err_q;
   logic [ACC_W-1:0] acc_q;
   logic [ZW-1:0]    z_addr_q;
   logic [OUT_W-1:0] z_data_q;

   logic [CW-1:0]       kmax, n_last, n_inc, ny_m1, kmin_next;
   logic                last_term, last_out, size_bad;
   logic [2*DATA_W-1:0] x_ext, y_ext, prod_raw;
   logic [ACC_W-1:0]    prod_ext, acc_sum, shifted;
   logic [OUT_W-1:0]    z_fmt;

   // ---------------- index arithmetic ----------------
   always_comb begin
      kmax      = (n_q < nx_q - ONE_C) ? n_q : nx_q - ONE_C;
      n_last    = nx_q + ny_q - TWO_C;
      n_inc     = n_q + ONE_C;
      ny_m1     = ny_q - ONE_C;
      kmin_next = (n_inc >= ny_m1) ? n_inc - ny_m1 : '0;
      last_term = (k_q == kmax);
      last_out  = (n_q == n_last);
      size_bad  = (bus.size_x == '0) || (bus.size_y == '0) ||
                  (bus.size_x > MAX_X_L) || (bus.size_y > MAX_Y_L);
   end

   // ---------------- product and accumulate ----------------
   // Extending both operands to 2*DATA_W and keeping the low half of the
   // product gives the exact signed or unsigned product.
   always_comb begin
      x_ext    = {{DATA_W{SIGNED & bus.mem_x_data[DATA_W-1]}}, bus.mem_x_data};
      y_ext    = {{DATA_W{SIGNED & bus.mem_y_data[DATA_W-1]}}, bus.mem_y_data};
      prod_raw = x_ext * y_ext;
      prod_ext = {{(ACC_W-2*DATA_W){SIGNED & prod_raw[2*DATA_W-1]}}, prod_raw};
      acc_sum  = acc_q + prod_ext;
   end

   // ---------------- output formatting f(acc) ----------------
   always_comb begin
      shifted = '0;
      if (SIGNED) shifted = $signed(acc_sum) >>> shift_q;
      else        shifted = acc_sum >> shift_q;
      z_fmt = shifted[OUT_W-1:0];
      if (sat_q) begin
         if (SIGNED) begin
            // in range only if all bits from OUT_W-1 upward agree
            if (!((&shifted[ACC_W-1:OUT_W-1]) || (~|shifted[ACC_W-1:OUT_W-1])))
               z_fmt = shifted[ACC_W-1] ? SMIN : SMAX;
         end else if (|shifted[ACC_W-1:OUT_W]) begin
            z_fmt = '1;
         end
      end
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (rst_a)     state <= S_IDLE;
      else if (en_s) state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = S_MAC;
         S_MAC: begin
            if (bad_q)          state_nxt = S_DONE;
            else if (last_term) state_nxt = S_DRAIN;
         end
         S_DRAIN: state_nxt = S_WRITE;
         S_WRITE: state_nxt = last_out ? S_DONE : S_MAC;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst_a) begin
         nx_q     <= '0;
         ny_q     <= '0;
         n_q      <= '0;
         k_q      <= '0;
         shift_q  <= '0;
         sat_q    <= 1'b0;
         bad_q    <= 1'b0;
         first_q  <= 1'b0;
         err_q    <= 1'b0;
         acc_q    <= '0;
         z_addr_q <= '0;
         z_data_q <= '0;
      end else if (en_s) begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  nx_q    <= CW'(bus.size_x);
                  ny_q    <= CW'(bus.size_y);
                  shift_q <= bus.shift;
                  sat_q   <= bus.sat_en;
                  bad_q   <= size_bad;
                  err_q   <= 1'b0;
                  n_q     <= '0;
                  k_q     <= '0;
                  first_q <= 1'b1;
                  acc_q   <= '0;
               end
            end
            S_MAC: begin
               if (bad_q) begin
                  err_q <= 1'b1;
               end else begin
                  // the first cycle of each output has no read data yet
                  if (!first_q) acc_q <= acc_sum;
                  first_q <= 1'b0;
                  if (!last_term) k_q <= k_q + ONE_C;
               end
            end
            S_DRAIN: begin
               acc_q    <= acc_sum;
               z_data_q <= z_fmt;
               z_addr_q <= n_q[ZW-1:0];
            end
            S_WRITE: begin
               if (!last_out) begin
                  n_q     <= n_inc;
                  k_q     <= kmin_next;
                  first_q <= 1'b1;
                  acc_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs ----------------
   // n-k is always below Ny, so the low YW bits of the difference suffice.
   assign bus.mem_x_addr = k_q[XW-1:0];
   assign bus.mem_y_addr = n_q[YW-1:0] - k_q[YW-1:0];
   assign bus.mem_z_addr = z_addr_q;
   assign bus.mem_z_data = z_data_q;
   assign bus.mem_z_we   = en_s && (state == S_WRITE);
   assign bus.busy       = (state == S_MAC) || (state == S_DRAIN) || (state == S_WRITE);
   assign bus.done       = (state == S_DONE);
   assign bus.err        = err_q;
endmodule

// File: tb/tb_conv1d_mac_engine.sv
// Directed testbench for conv1d_mac_engine (16-bit signed operands,
// 16-bit output, 16-deep X/Y memories). Expected Z words come from a
// direct convolution model and are queued when a job is launched; the
// Z-write monitor pops and compares them as the engine writes.
module tb_conv1d_mac_engine;
   localparam int DATA_W = 16;
   localparam int OUT_W  = 16;
   localparam int MAX_X  = 16;
   localparam int MAX_Y  = 16;

   logic clk = 1'b0;
   logic rst_a;
   logic en_s;

   conv1d_mac_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y)) bus ();

   conv1d_mac_engine #(
      .DATA_W(DATA_W), .OUT_W(OUT_W), .MAX_X(MAX_X), .MAX_Y(MAX_Y),
      .SIGNED(1'b1), .ACC_W(2*DATA_W+7)
   ) dut (
      .clk   (clk),
      .rst_a (rst_a),
      .en_s  (en_s),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // synchronous X/Y memories, frozen together with the engine by en_s
   logic [15:0] xmem [16];
   logic [15:0] ymem [16];
   always @(posedge clk) begin
      if (en_s) begin
         bus.mem_x_data <= xmem[bus.mem_x_addr];
         bus.mem_y_data <= ymem[bus.mem_y_addr];
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- model and scoreboard ----------------
   typedef struct {
      logic [4:0]  addr;
      logic [15:0] data;
   } zexp_t;
   zexp_t zq[$];
   int    wr_cnt = 0;

   int xv [16];
   int yv [16];
   int nx, ny, sh;
   bit sat;

   function automatic logic [15:0] model_z(input int n);
      longint s;
      s = 0;
      for (int k = 0; k < nx; k++)
         if (n - k >= 0 && n - k < ny) s += longint'(xv[k]) * longint'(yv[n-k]);
      s = s >>> sh;
      if (sat) begin
         if (s > 32767)       s = 32767;
         else if (s < -32768) s = -32768;
      end
      return s[15:0];
   endfunction

   always @(negedge clk) begin
      zexp_t e;
      if (bus.mem_z_we === 1'b1) begin
         wr_cnt++;
         n_assert++;
         assert (zq.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_write: observed addr %0d data %0d expected no write",
                   bus.mem_z_addr, bus.mem_z_data);
         end
         if (zq.size() != 0) begin
            e = zq.pop_front();
            chk("z_addr", bus.mem_z_addr, e.addr);
            chk("z_data", bus.mem_z_data, e.data);
         end
      end
   end

   task automatic prep(input bit legal);
      int n;
      for (int k = 0; k < 16; k++) begin
         xmem[k] = xv[k][15:0];
         ymem[k] = yv[k][15:0];
      end
      if (legal)
         for (n = 0; n <= nx + ny - 2; n++) zq.push_back('{addr: n[4:0], data: model_z(n)});
   endtask

   task automatic drive_start();
      @(posedge clk); #1;
      bus.size_x = nx[4:0];
      bus.size_y = ny[4:0];
      bus.shift  = sh[4:0];
      bus.sat_en = sat;
      bus.start  = 1'b1;
      en_s       = 1'b1;
   endtask

   // stall: en_s high only on even cycles after accept; poke: start pulse mid-job
   task automatic run_job(input string tag, input bit stall, input bit poke,
                          input int exp_lat, input int exp_wr, input bit exp_err);
      int j, lat;
      bit busy_ok;
      prep(!exp_err);
      wr_cnt = 0;
      drive_start();
      j = 0; lat = -1; busy_ok = 1'b1;
      while (lat < 0 && j < 400) begin
         @(negedge clk);
         if (j > 0 && bus.done === 1'b1 && en_s) lat = j;
         else if (j > 0 && bus.busy !== 1'b1 && bus.done !== 1'b1) busy_ok = 1'b0;
         if (lat < 0) begin
            @(posedge clk); #1;
            j++;
            bus.start = poke && (j == 6);
            en_s      = stall ? (j % 2 == 0) : 1'b1;
         end
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_busy_during"}, busy_ok, 1);
      chk({tag, "_busy_at_done"}, bus.busy, 0);
      chk({tag, "_err_at_done"}, bus.err, exp_err);
      @(posedge clk); #1;
      bus.start = 1'b0;
      en_s      = 1'b1;
      @(negedge clk);
      chk({tag, "_writes"}, wr_cnt, exp_wr);
      chk({tag, "_queue_left"}, zq.size(), 0);
      chk({tag, "_done_after"}, bus.done, 0);
      chk({tag, "_err_idle"}, bus.err, exp_err);
      zq.delete();
   endtask

   task automatic set_t1();
      for (int k = 0; k < 16; k++) begin xv[k] = 0; yv[k] = 0; end
      xv[0] = 1; xv[1] = 2; xv[2] = 3;
      yv[0] = 1; yv[1] = 1;
      nx = 3; ny = 2; sh = 0; sat = 1'b0;
   endtask

   initial begin : stim
      int j, dn, wr0;
      for (int k = 0; k < 16; k++) begin xmem[k] = '0; ymem[k] = '0; end
      rst_a = 1'b1; en_s = 1'b1;
      bus.start = 1'b0; bus.size_x = '0; bus.size_y = '0;
      bus.shift = '0; bus.sat_en = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_a = 1'b0;
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_we", bus.mem_z_we, 0);
      chk("rst_zdata", bus.mem_z_data, 0);
      chk("rst_zaddr", bus.mem_z_addr, 0);
      chk("rst_xaddr", bus.mem_x_addr, 0);
      chk("rst_yaddr", bus.mem_y_addr, 0);

      // basic: [1,2,3] * [1,1]
      set_t1();
      run_job("t1", 1'b0, 1'b0, 15, 4, 1'b0);

      // ramp through a single-tap filter
      for (int k = 0; k < 16; k++) begin xv[k] = k; yv[k] = 0; end
      yv[0] = 1; nx = 10; ny = 1; sh = 0; sat = 1'b0;
      run_job("ramp_y1", 1'b0, 1'b0, 31, 10, 1'b0);
      yv[0] = 4; sh = 2;
      run_job("ramp_y4_sh2", 1'b0, 1'b0, 31, 10, 1'b0);

      // saturation vs truncation
      for (int k = 0; k < 16; k++) begin xv[k] = 0; yv[k] = 0; end
      xv[0] = 32767; xv[1] = 32767; yv[0] = 32767; yv[1] = 32767;
      nx = 2; ny = 2; sh = 0; sat = 1'b1;
      run_job("sat_pos", 1'b0, 1'b0, 11, 3, 1'b0);
      sat = 1'b0;
      run_job("trunc", 1'b0, 1'b0, 11, 3, 1'b0);
      xv[1] = 0; yv[1] = 0; xv[0] = -32768; yv[0] = -32768;
      nx = 1; ny = 1; sat = 1'b1;
      run_job("sat_minmin", 1'b0, 1'b0, 4, 1, 1'b0);

      // illegal sizes, then a legal job clears err
      nx = 0; ny = 2;
      run_job("err_nx0", 1'b0, 1'b0, 2, 0, 1'b1);
      set_t1();
      run_job("t1_after_err", 1'b0, 1'b0, 15, 4, 1'b0);
      nx = 17; ny = 2;
      run_job("err_nx17", 1'b0, 1'b0, 2, 0, 1'b1);

      // stalls and an ignored mid-job start
      set_t1();
      run_job("t1_stall_poke", 1'b1, 1'b1, 30, 4, 1'b0);
      run_job("t1_poke", 1'b0, 1'b1, 15, 4, 1'b0);

      // reset after the second write
      set_t1();
      prep(1'b1);
      wr_cnt = 0;
      drive_start();
      j = 0;
      while (wr_cnt < 2 && j < 100) begin
         @(negedge clk);
         @(posedge clk); #1;
         bus.start = 1'b0;
         j++;
      end
      chk("rstjob_reached_2_writes", wr_cnt, 2);
      rst_a = 1'b1;
      @(posedge clk); #1;
      rst_a = 1'b0;
      @(negedge clk);
      chk("rstjob_busy", bus.busy, 0);
      chk("rstjob_done", bus.done, 0);
      chk("rstjob_we", bus.mem_z_we, 0);
      chk("rstjob_zdata", bus.mem_z_data, 0);
      chk("rstjob_xaddr", bus.mem_x_addr, 0);
      zq.delete();
      wr0 = wr_cnt; dn = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done === 1'b1) dn++;
      end
      chk("rstjob_no_more_writes", wr_cnt, wr0);
      chk("rstjob_no_done", dn, 0);
      run_job("t1_after_reset", 1'b0, 1'b0, 15, 4, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
